// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and buffered
// long-latency returns fill the idle slots. It also keeps a pending scoreboard for ID hazards.
module wb_port_arb #(
   parameter int DATA_W     = 17,
   parameter int ADDR_W     = 4,
   parameter int DEPTH      = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_DM_WB,
   input  logic [ADDR_W-1:0] dst_addr_DM_WB,
   input  logic [DATA_W-1:0] rf_w_data_DM_WB,
   input  logic              ext_vld,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_data,
   output logic              ext_rdy,
   input  logic              issue_vld,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              hazard,
   output logic              starve_req,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_dst_addr,
   output logic [DATA_W-1:0] rf_w_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int NREG  = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ret_t;

   ret_t              buf_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic [NREG-1:0]   pending, pending_nxt;
   logic [3:0]        starve_cnt;

   logic full, empty, push, pop;
   ret_t head;

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = buf_mem[rd_ptr];

   // No pop-through credit: a full buffer stays not-ready for the whole cycle.
   assign ext_rdy = !full && !rst;
   assign push    = ext_vld && ext_rdy;
   assign pop     = !rst && !we_DM_WB && !empty;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      rf_we       = 1'b0;
      rf_dst_addr = dst_addr_DM_WB;
      rf_w_data   = rf_w_data_DM_WB;
      if (!rst) begin
         if (we_DM_WB) begin
            rf_we = 1'b1;
         end else if (!empty) begin
            rf_we       = (head.addr != '0);
            rf_dst_addr = head.addr;
            rf_w_data   = head.data;
         end
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by count and the pointers.
   always_ff @(posedge clk) begin
      if (push) buf_mem[wr_ptr] <= '{addr: ext_addr, data: ext_data};
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Clear on commit first, then set, so a same-cycle issue to the same register wins.
   always_comb begin
      pending_nxt = pending;
      if (pop && head.addr != '0) pending_nxt[head.addr] = 1'b0;
      if (issue_vld && issue_addr != '0) pending_nxt[issue_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= pending_nxt;
   end

   assign hazard = (chk_addr1 != '0 && pending[chk_addr1]) ||
                   (chk_addr2 != '0 && pending[chk_addr2]);

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         starve_req <= 1'b0;
      end else if (pop) begin
         starve_cnt <= '0;
         starve_req <= 1'b0;
      end else begin
         if (!empty && we_DM_WB && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 1'b1;
         starve_req <= (starve_cnt >= 4'(STARVE_LIM));
      end
   end

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb. Each step drives its inputs just after a rising edge,
// then checks the outputs mid-cycle against hand-computed values.
module tb_wb_port_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_DM_WB;
   logic [3:0]  dst_addr_DM_WB;
   logic [16:0] rf_w_data_DM_WB;
   logic        ext_vld;
   logic [3:0]  ext_addr;
   logic [16:0] ext_data;
   logic        ext_rdy;
   logic        issue_vld;
   logic [3:0]  issue_addr;
   logic [3:0]  chk_addr1, chk_addr2;
   logic        hazard, starve_req, rf_we;
   logic [3:0]  rf_dst_addr;
   logic [16:0] rf_w_data;

   int total = 0;
   int bad   = 0;

   wb_port_arb #(.DATA_W(17), .ADDR_W(4), .DEPTH(2), .STARVE_LIM(4)) dut (
      .clk(clk), .rst(rst),
      .we_DM_WB(we_DM_WB), .dst_addr_DM_WB(dst_addr_DM_WB), .rf_w_data_DM_WB(rf_w_data_DM_WB),
      .ext_vld(ext_vld), .ext_addr(ext_addr), .ext_data(ext_data), .ext_rdy(ext_rdy),
      .issue_vld(issue_vld), .issue_addr(issue_addr),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .hazard(hazard), .starve_req(starve_req),
      .rf_we(rf_we), .rf_dst_addr(rf_dst_addr), .rf_w_data(rf_w_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_port(input string tag, input logic we, input logic [3:0] a,
                             input logic [16:0] d);
      check({tag, ".we"}, 32'(rf_we), 32'(we));
      if (we) begin
         check({tag, ".addr"}, 32'(rf_dst_addr), 32'(a));
         check({tag, ".data"}, 32'(rf_w_data), 32'(d));
      end
   endtask

   initial begin
      rst = 1'b1; we_DM_WB = 1'b0; dst_addr_DM_WB = '0; rf_w_data_DM_WB = '0;
      ext_vld = 1'b0; ext_addr = '0; ext_data = '0;
      issue_vld = 1'b0; issue_addr = '0; chk_addr1 = '0; chk_addr2 = '0;

      // Reset: the port and ext_rdy stay low even when the pipeline asks to write.
      tick(); tick();
      we_DM_WB = 1'b1; dst_addr_DM_WB = 4'd9; rf_w_data_DM_WB = 17'h5;
      #1;
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_ext_rdy", 32'(ext_rdy), 32'd0);
      rst = 1'b0; we_DM_WB = 1'b0;
      tick();
      check("idle_rf_we", 32'(rf_we), 32'd0);
      check("idle_ext_rdy", 32'(ext_rdy), 32'd1);
      check("idle_starve", 32'(starve_req), 32'd0);
      check("idle_hazard", 32'(hazard), 32'd0);

      // Single return on an idle pipeline: commits on the next cycle, with no bypass.
      ext_vld = 1'b1; ext_addr = 4'd5; ext_data = 17'h1ABCD;
      #1;
      check("t1_nobypass", 32'(rf_we), 32'd0);
      tick();
      ext_vld = 1'b0;
      #1;
      check_port("t1_commit", 1'b1, 4'd5, 17'h1ABCD);
      check("t1_rdy", 32'(ext_rdy), 32'd1);
      tick();
      check("t1_empty", 32'(rf_we), 32'd0);

      // Starvation: a continuous pipeline writeback with three returns offered.
      we_DM_WB = 1'b1; dst_addr_DM_WB = 4'd9; rf_w_data_DM_WB = 17'h00111;
      ext_vld = 1'b1; ext_addr = 4'd1; ext_data = 17'h11;
      #1;
      check_port("t2_passthru", 1'b1, 4'd9, 17'h00111);
      tick();
      ext_addr = 4'd2; ext_data = 17'h22;
      #1;
      check("t2_rdy_1", 32'(ext_rdy), 32'd1);
      tick();
      ext_addr = 4'd4; ext_data = 17'h44;
      #1;
      check("t2_full", 32'(ext_rdy), 32'd0);
      tick();
      check("t2_starve_b3", 32'(starve_req), 32'd0);
      tick();
      tick();
      check("t2_starve_b5", 32'(starve_req), 32'd0);
      tick();
      check("t2_starve_on", 32'(starve_req), 32'd1);
      we_DM_WB = 1'b0;
      #1;
      check_port("t2_head1", 1'b1, 4'd1, 17'h11);
      check("t2_full_pop", 32'(ext_rdy), 32'd0);
      check("t2_starve_hold", 32'(starve_req), 32'd1);
      tick();
      check("t2_starve_off", 32'(starve_req), 32'd0);
      check("t2_rdy_back", 32'(ext_rdy), 32'd1);
      check_port("t2_head2", 1'b1, 4'd2, 17'h22);
      tick();
      ext_vld = 1'b0;
      #1;
      check_port("t2_head4", 1'b1, 4'd4, 17'h44);
      tick();
      check("t2_drained", 32'(rf_we), 32'd0);

      // Scoreboard set and clear for r3, checked on both source ports.
      issue_vld = 1'b1; issue_addr = 4'd3; chk_addr1 = 4'd3;
      #1;
      check("t3_haz_pre", 32'(hazard), 32'd0);
      tick();
      issue_vld = 1'b0;
      #1;
      check("t3_haz_set", 32'(hazard), 32'd1);
      chk_addr1 = 4'd0; chk_addr2 = 4'd3;
      #1;
      check("t3_haz_src2", 32'(hazard), 32'd1);
      ext_vld = 1'b1; ext_addr = 4'd3; ext_data = 17'h3;
      tick();
      ext_vld = 1'b0;
      #1;
      check_port("t3_commit", 1'b1, 4'd3, 17'h3);
      check("t3_haz_commit", 32'(hazard), 32'd1);
      tick();
      check("t3_haz_clr", 32'(hazard), 32'd0);

      // Issue to r7 in the same cycle that a return to r7 commits: the set wins.
      chk_addr2 = 4'd0; chk_addr1 = 4'd7;
      ext_vld = 1'b1; ext_addr = 4'd7; ext_data = 17'h77;
      tick();
      ext_vld = 1'b0; issue_vld = 1'b1; issue_addr = 4'd7;
      #1;
      check_port("t4_commit", 1'b1, 4'd7, 17'h77);
      tick();
      issue_vld = 1'b0;
      #1;
      check("t4_set_wins", 32'(hazard), 32'd1);

      // A return to r0 never writes but is popped; r0 never raises a hazard.
      ext_vld = 1'b1; ext_addr = 4'd0; ext_data = 17'h1FFFF;
      issue_vld = 1'b1; issue_addr = 4'd0;
      tick();
      issue_vld = 1'b0; chk_addr1 = 4'd0; chk_addr2 = 4'd0;
      ext_addr = 4'd6; ext_data = 17'h66;
      #1;
      check("t5_r0_nowrite", 32'(rf_we), 32'd0);
      check("t5_r0_hazard", 32'(hazard), 32'd0);
      tick();
      ext_vld = 1'b0;
      #1;
      check_port("t5_after_r0", 1'b1, 4'd6, 17'h66);

      // Reset with two buffered entries and r1, r2, r7 pending.
      issue_vld = 1'b1; issue_addr = 4'd1;
      tick();
      issue_addr = 4'd2;
      we_DM_WB = 1'b1; dst_addr_DM_WB = 4'd8; rf_w_data_DM_WB = 17'h8;
      ext_vld = 1'b1; ext_addr = 4'd10; ext_data = 17'hA;
      tick();
      issue_vld = 1'b0;
      ext_addr = 4'd11; ext_data = 17'hB;
      tick();
      ext_vld = 1'b0; chk_addr1 = 4'd1; chk_addr2 = 4'd2;
      #1;
      check("t6_full", 32'(ext_rdy), 32'd0);
      check("t6_haz_pre", 32'(hazard), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_we", 32'(rf_we), 32'd0);
      check("t6_rst_rdy", 32'(ext_rdy), 32'd0);
      tick();
      rst = 1'b0; we_DM_WB = 1'b0;
      tick();
      check("t6_empty", 32'(rf_we), 32'd0);
      check("t6_rdy", 32'(ext_rdy), 32'd1);
      check("t6_starve", 32'(starve_req), 32'd0);
      for (int a = 0; a < 16; a++) begin
         chk_addr1 = 4'(a); chk_addr2 = 4'(a);
         #1;
         check($sformatf("t6_haz_r%0d", a), 32'(hazard), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
